// File: rtl/latch_ctrl_pkg.sv
// Shared types for the latch bank sequencer: FSM state encoding and requester op codes.
package latch_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StStrobe = 2'd2,
        StHold   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OpWrite = 2'b00,
        OpSet   = 2'b01,
        OpClear = 2'b10,
        OpNop   = 2'b11
    } op_e;

    // Wide enough for strobe lengths up to 15 cycles.
    localparam int unsigned CntW = 4;

endpackage

// File: rtl/latch_bank_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after the pointer.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IdxW  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             valid_o
);

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        // First pass covers ptr..N_REQ-1, second pass wraps to 0..ptr-1.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!valid_o && (i >= 32'(ptr_i)) && req_i[i]) begin
                gnt_o[i] = 1'b1;
                valid_o  = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!valid_o && (i < 32'(ptr_i)) && req_i[i]) begin
                gnt_o[i] = 1'b1;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Shares one gated-latch bank among N_REQ requesters: round-robin grant, then
// setup / strobe / hold sequencing on the latch pins with all outputs registered.
module latch_bank_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DW         = 8,
    parameter int unsigned STROBE_CYC = 1
) (
    input  logic               clk_i,
    input  logic               clr_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*DW-1:0] wr_data_i,
    input  logic [N_REQ*2-1:0] op_i,
    output logic [N_REQ-1:0]   gnt_o,
    output logic               done_o,
    output logic               busy_o,
    output logic [DW-1:0]      lat_d_o,
    output logic               lat_en_o,
    output logic               lat_pre_n_o,
    output logic               lat_clr_n_o
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [DW-1:0]     lat_d_q, lat_d_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              lat_en_q, lat_en_d;
    logic              pre_n_q, pre_n_d;
    logic              clr_n_q, clr_n_d;

    logic [N_REQ-1:0]  arb_gnt;
    logic              arb_valid;
    logic [IdxW-1:0]   sel_idx;
    logic [DW-1:0]     sel_data;
    op_e               sel_op;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IdxW  (IdxW)
    ) u_arb (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid)
    );

    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        sel_op   = OpNop;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_idx  = IdxW'(i);
                sel_data = wr_data_i[i*DW +: DW];
                sel_op   = op_e'(op_i[i*2 +: 2]);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        lat_d_d  = lat_d_q;
        done_d   = 1'b0;
        lat_en_d = 1'b0;
        pre_n_d  = 1'b1;
        clr_n_d  = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = StSetup;
                    gnt_d   = arb_gnt;
                    idx_d   = sel_idx;
                    op_d    = sel_op;
                    lat_d_d = sel_data;
                end
            end
            StSetup: begin
                state_d  = StStrobe;
                cnt_d    = CntW'(STROBE_CYC - 1);
                // Decoded from op so preset and clear can never be low together.
                lat_en_d = (op_q == OpWrite);
                pre_n_d  = (op_q != OpSet);
                clr_n_d  = (op_q != OpClear);
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    done_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_q - CntW'(1);
                    lat_en_d = lat_en_q;
                    pre_n_d  = pre_n_q;
                    clr_n_d  = clr_n_q;
                end
            end
            StHold: begin
                state_d = StIdle;
                gnt_d   = '0;
                ptr_d   = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + IdxW'(1);
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q  <= StIdle;
            op_q     <= OpNop;
            idx_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            lat_d_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            lat_en_q <= 1'b0;
            pre_n_q  <= 1'b1;
            clr_n_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            lat_d_q  <= lat_d_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            lat_en_q <= lat_en_d;
            pre_n_q  <= pre_n_d;
            clr_n_q  <= clr_n_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign lat_d_o     = lat_d_q;
    assign lat_en_o    = lat_en_q;
    assign lat_pre_n_o = pre_n_q;
    assign lat_clr_n_o = clr_n_q;

endmodule
